regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_param.sv
// Parameterised register file: two combinational read ports with write bypass, byte-enabled
// writes, a hard-wired zero register and one I/O-mapped register with a dirty/ack handshake.
module regfile_param #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned IO_REG = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0] io_in,
    input  logic             io_load,
    output logic [WIDTH-1:0] io_out,
    output logic             io_dirty,
    input  logic             io_ack
);

    localparam int unsigned NB = WIDTH / 8;
    localparam logic [AW-1:0] IoAddr = AW'(IO_REG);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] merged;
    logic             cpu_wr;
    logic             io_wr_qual;
    logic             io_dirty_q, io_dirty_d;

    // Value the addressed register will hold after the edge if the CPU write lands.
    always_comb begin
        merged = regs_q[wa];
        for (int b = 0; b < NB; b++) begin
            if (wbe[b]) merged[8*b +: 8] = wd[8*b +: 8];
        end
    end

    assign cpu_wr     = we && (wa != '0);
    // io_load overrides a same-edge CPU write to the I/O register, so that write cannot dirty it.
    assign io_wr_qual = cpu_wr && (wa == IoAddr) && !io_load && (|wbe);

    always_comb begin
        io_dirty_d = io_dirty_q;
        if (io_wr_qual) begin
            io_dirty_d = 1'b1;
        end else if (io_ack) begin
            io_dirty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            io_dirty_q <= 1'b0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (io_load && (AW'(i) == IoAddr)) begin
                    regs_q[i] <= io_in;
                end else if (cpu_wr && (wa == AW'(i))) begin
                    regs_q[i] <= merged;
                end
            end
            io_dirty_q <= io_dirty_d;
        end
    end

    function automatic logic [WIDTH-1:0] rd_port(input logic [AW-1:0] ra);
        logic [WIDTH-1:0] v;
        if (reset || (ra == '0)) begin
            v = '0;
        end else if (io_load && (ra == IoAddr)) begin
            v = io_in;
        end else if (we && (ra == wa)) begin
            v = merged;
        end else begin
            v = regs_q[ra];
        end
        return v;
    endfunction

    assign rd1      = rd_port(ra1);
    assign rd2      = rd_port(ra2);
    assign io_out   = regs_q[IoAddr];
    assign io_dirty = io_dirty_q;

endmodule
